fifo_word_packer: RTL and testbench
===================================

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter WIDTH, 8, bit width of one input element; matches the FIFO data width.
REQ-002 Parameter LANES, 4, input elements packed per output word; legal range 2..8.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  FIFO read-side valid; connects to the FIFO r_enable.
REQ-006 Port in_data  input  WIDTH  FIFO read data; connects to the FIFO r_data.
REQ-007 Port in_ready  output  1  consumer ready; drives the FIFO r_ready.
REQ-008 Port flush  input  1  single-cycle request to emit a partially filled word.
REQ-009 Port out_valid  output  1  packed word available.
REQ-010 Port out_data  output  WIDTH*LANES  packed word; lane 0 in the least significant WIDTH bits.
REQ-011 Port out_keep  output  LANES  per-lane valid mask for out_data.
REQ-012 Port out_ready  input  1  downstream accepts the word.
REQ-013 Port word_count  output  16  count of completed output handshakes; saturates at 0xFFFF.

Function
REQ-014 An element SHALL be accepted only in a cycle where in_valid and in_ready are both 1; accepted elements fill lanes in order 0, 1, ... LANES-1.
REQ-015 The state machine SHALL have three states: IDLE (no lanes filled), FILL (1..LANES-1 lanes filled), and HOLD (word presented).
REQ-016 in_ready SHALL be 1 in IDLE and FILL, and SHALL equal out_ready in HOLD; this is a combinational path.
REQ-017 An accept that fills lane LANES-1 SHALL move to HOLD with out_keep all ones, and out_valid SHALL be 1 starting the next cycle.
REQ-018 flush in FILL SHALL move to HOLD with out_keep set to the filled lanes only; unfilled lanes of out_data SHALL be zero.
REQ-019 flush in the same cycle as an accept SHALL include that element first; if that element fills the word, exactly one full word SHALL result and no empty word.
REQ-020 flush in IDLE or HOLD SHALL be ignored and SHALL never produce a word with out_keep equal to zero.
REQ-021 In HOLD, out_valid, out_data and out_keep SHALL remain stable until out_valid and out_ready are both 1.
REQ-022 On the output handshake the next state SHALL be FILL with the concurrent element in lane 0 if an element is accepted that cycle, otherwise IDLE; this gives one word per LANES cycles at full rate.
REQ-023 word_count SHALL increment by 1 on each output handshake and SHALL hold at 0xFFFF.
REQ-024 The block SHALL NOT drop, duplicate or reorder elements.

Reset
REQ-025 rst SHALL immediately force state IDLE, clear the lane count, set out_valid to 0, out_data to 0, out_keep to 0 and word_count to 0.
REQ-026 Partially filled lanes SHALL be discarded on reset; the first element accepted after rst deasserts SHALL land in lane 0.
REQ-027 in_ready SHALL be 1 from the first cycle after rst deasserts.

Structure
REQ-028 fifo_pkg SHALL hold the state enum typedef (IDLE, FILL, HOLD) and the default WIDTH and LANES constants shared with the FIFO interface.
REQ-029 The block SHALL be a single module with no sub-modules; the lane register file and the lane counter SHALL be local to it.

Verification
REQ-030 WIDTH=8, LANES=4, out_ready=1; stimulus: 0x11, 0x22, 0x33, 0x44 back-to-back -> one word 0x44332211 with out_keep 4'b1111, out_valid 1 on the cycle after the 4th accept.
REQ-031 Stimulus: 0xAA, 0xBB, then flush -> word 0x0000BBAA with out_keep 4'b0011, then IDLE.
REQ-032 Word complete, out_ready=0 for 5 cycles -> out_valid, out_data and out_keep stable; in_ready=0; FIFO read data not consumed until out_ready=1.
REQ-033 flush asserted in the same cycle as the 4th element -> exactly one word with out_keep 4'b1111; word_count increments by 1.
REQ-034 rst pulsed after 2 elements -> out_valid=0 at once; the next 0x01..0x04 yields 0x04030201.
REQ-035 Continuous stream of 12 elements with out_ready=1 -> 3 words, no idle cycle on in_ready, word_count=3.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side word packer.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } pack_state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// Packs LANES consecutive FIFO read elements into one wide word with a lane keep mask.
//   state | meaning
//   IDLE  | no lanes filled
//   FILL  | 1..LANES-1 lanes filled
//   HOLD  | word presented on out_*, waiting for out_ready
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int LANES = FIFO_LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]       out_keep,
  input  logic                   out_ready,
  output logic [15:0]            word_count
);

  localparam int DW = WIDTH * LANES;
  localparam int CW = $clog2(LANES + 1);

  pack_state_t    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  data_q, data_d;
  logic [LANES-1:0] keep_q, keep_d;
  logic [15:0]    word_count_q;
  logic           accept;
  logic           handshake;

  // In HOLD the upstream may only advance when the held word leaves this cycle.
  assign in_ready  = (state_q != HOLD) || out_ready;
  assign accept    = in_valid && in_ready;
  assign handshake = (state_q == HOLD) && out_ready;

  assign out_valid  = (state_q == HOLD);
  assign out_data   = data_q;
  assign out_keep   = keep_q;
  assign word_count = word_count_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          data_d = data_q | (DW'(in_data) << (WIDTH * int'(cnt_q)));
          keep_d = keep_q | (LANES'(1) << cnt_q);
          cnt_d  = cnt_q + CW'(1);
          // the accepted element is folded in before a concurrent flush is honoured
          if ((int'(cnt_q) == LANES - 1) || flush) state_d = HOLD;
          else                                     state_d = FILL;
        end else if (flush && (state_q == FILL)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (in_valid) begin
            data_d  = DW'(in_data);
            keep_d  = LANES'(1);
            cnt_d   = CW'(1);
            state_d = FILL;
          end else begin
            data_d  = '0;
            keep_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        data_d  = '0;
        keep_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      word_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      if (handshake && (word_count_q != 16'hFFFF)) word_count_q <= word_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed and randomized checks of fifo_word_packer against a queue-based reference model.
module tb_fifo_word_packer;

  localparam int W = 8;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic           flush;
  logic           out_valid;
  logic [W*L-1:0] out_data;
  logic [L-1:0]   out_keep;
  logic           out_ready;
  logic [15:0]    word_count;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_wc;

  fifo_word_packer #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep),
    .out_ready(out_ready), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    exp_wc = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_keep !== '0) begin failures++; $display("FAIL reset_out_keep got=%b exp=0", out_keep); end
    checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
    tick();
    rst = 1'b0;
    exp_wc = '0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    tick();
  endtask

  task automatic test_full_word();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h11 * (i + 1));
      tick();
      if (i < 3) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_early_valid lane=%0d got=%0b exp=0", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%0b exp=1", out_valid); end
    checks++; if (out_data !== 32'h44332211) begin failures++; $display("FAIL full_data got=%h exp=44332211", out_data); end
    checks++; if (out_keep !== 4'b1111) begin failures++; $display("FAIL full_keep got=%b exp=1111", out_keep); end
    tick();
    exp_wc++;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_after_valid got=%0b exp=0", out_valid); end
    checks++; if (word_count !== exp_wc) begin failures++; $display("FAIL full_word_count got=%0d exp=%0d", word_count, exp_wc); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hAA; tick();
    in_data = 8'hBB; tick();
    in_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_valid got=%0b exp=1", out_valid); end
    checks++; if (out_data !== 32'h0000BBAA) begin failures++; $display("FAIL flush_data got=%h exp=0000bbaa", out_data); end
    checks++; if (out_keep !== 4'b0011) begin failures++; $display("FAIL flush_keep got=%b exp=0011", out_keep); end
    tick();
    exp_wc++;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_idle_valid got=%0b exp=0", out_valid); end
    // flush with nothing buffered must not create a word
    flush = 1'b1; tick();
    flush = 1'b0; tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty_valid got=%0b exp=0", out_valid); end
    checks++; if (word_count !== exp_wc) begin failures++; $display("FAIL flush_word_count got=%0d exp=%0d", word_count, exp_wc); end
    in_valid = 1'b1; in_data = 8'h5A; flush = 1'b1; tick();
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_data !== 32'h0000005A || out_keep !== 4'b0001) begin
      failures++; $display("FAIL flush_single got=%h/%b exp=0000005a/0001", out_data, out_keep);
    end
    tick();
    exp_wc++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hA0 + i); tick();
    end
    in_valid = 1'b1; in_data = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", c, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hA3A2A1A0 || out_keep !== 4'b1111) begin
        failures++; $display("FAIL bp_stable cyc=%0d got=%0b/%h/%b exp=1/a3a2a1a0/1111", c, out_valid, out_data, out_keep);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
    tick();
    exp_wc++;
    in_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    checks++; if (out_data !== 32'h000000EE || out_keep !== 4'b0001) begin
      failures++; $display("FAIL bp_held_elem got=%h/%b exp=000000ee/0001", out_data, out_keep);
    end
    tick();
    exp_wc++;
    checks++; if (word_count !== exp_wc) begin failures++; $display("FAIL bp_word_count got=%0d exp=%0d", word_count, exp_wc); end
  endtask

  task automatic test_flush_on_last();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hC0 + i); flush = (i == 3); tick();
    end
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_data !== 32'hC3C2C1C0 || out_keep !== 4'b1111) begin
      failures++; $display("FAIL last_flush_word got=%h/%b exp=c3c2c1c0/1111", out_data, out_keep);
    end
    tick();
    exp_wc++;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL last_flush_no_empty got=%0b exp=0", out_valid); end
    checks++; if (word_count !== exp_wc) begin failures++; $display("FAIL last_flush_count got=%0d exp=%0d", word_count, exp_wc); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h77; tick();
    in_data = 8'h88; tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_keep !== '0 || word_count !== 16'd0) begin
      failures++; $display("FAIL mid_reset got=%0b/%b/%0d exp=0/0000/0", out_valid, out_keep, word_count);
    end
    tick();
    rst = 1'b0;
    exp_wc = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1); tick();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin
      failures++; $display("FAIL mid_reset_word got=%0b/%h exp=1/04030201", out_valid, out_data);
    end
    tick();
    exp_wc++;
  endtask

  task automatic test_stream();
    logic [W-1:0] e [12];
    logic [W*L-1:0] w;
    int wi;
    apply_reset();
    wi = 0;
    for (int i = 0; i < 12; i++) e[i] = 8'($urandom);
    out_ready = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      in_valid = (c < 12);
      in_data  = (c < 12) ? e[c] : '0;
      #1;
      if (c < 12) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cyc=%0d got=%0b exp=1", c, in_ready); end
      end
      if (out_valid === 1'b1) begin
        w = '0;
        for (int j = 0; j < L; j++) w[j*W +: W] = e[wi*L + j];
        checks++; if (out_data !== w) begin failures++; $display("FAIL stream_word idx=%0d got=%h exp=%h", wi, out_data, w); end
        if (wi < 2) wi++;
        else wi = 3;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (wi !== 3) begin failures++; $display("FAIL stream_words got=%0d exp=3", wi); end
    checks++; if (word_count !== 16'd3) begin failures++; $display("FAIL stream_word_count got=%0d exp=3", word_count); end
  endtask

  task automatic test_random();
    logic [W-1:0] pending [$];
    logic [W*L-1:0] m_data;
    logic [L-1:0]   m_keep;
    bit outstanding, was_holding, acc, exp_ready;
    apply_reset();
    outstanding = 0;
    m_data = '0; m_keep = '0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      exp_ready = !outstanding || out_ready;
      checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", c, in_ready, exp_ready); end
      checks++; if (out_valid !== outstanding) begin failures++; $display("FAIL rand_out_valid cyc=%0d got=%0b exp=%0b", c, out_valid, outstanding); end
      if (outstanding) begin
        checks++; if (out_data !== m_data || out_keep !== m_keep) begin
          failures++; $display("FAIL rand_word cyc=%0d got=%h/%b exp=%h/%b", c, out_data, out_keep, m_data, m_keep);
        end
      end
      was_holding = outstanding;
      acc = in_valid && exp_ready;
      if (outstanding && out_ready) begin
        outstanding = 0;
        if (exp_wc != 16'hFFFF) exp_wc++;
      end
      if (acc) pending.push_back(in_data);
      if ((pending.size() == L) || (flush && !was_holding && pending.size() > 0)) begin
        m_data = '0;
        m_keep = '0;
        foreach (pending[j]) begin
          m_data[j*W +: W] = pending[j];
          m_keep[j] = 1'b1;
        end
        pending.delete();
        outstanding = 1;
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (word_count !== exp_wc) begin failures++; $display("FAIL rand_word_count got=%0d exp=%0d", word_count, exp_wc); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_backpressure();
    test_flush_on_last();
    test_reset_mid();
    test_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
